// File: rtl/axi_stream_pkt_gen.sv
// Command-driven AXI4-Stream packet source: one incrementing-byte packet per command.
// Optional statistics counters are enabled by defining AXI_STREAM_PKT_GEN_STATS_EN.
package axi_stream_pkt_gen_pkg;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } axis_t;

  typedef struct packed {
    logic  tvalid;
    axis_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

module axi_stream_pkt_gen #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DestWidth = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned LenWidth  = 16,
  parameter type axi_stream_req_t  = axi_stream_pkt_gen_pkg::axis_req_t,
  parameter type axi_stream_rsp_t  = axi_stream_pkt_gen_pkg::axis_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic [IdWidth-1:0]   cmd_id_i,
  input  logic [DestWidth-1:0] cmd_dest_i,
  input  logic [UserWidth-1:0] cmd_user_i,
  input  logic [7:0]           cmd_seed_i,
  output axi_stream_req_t      tx_req_o,
  input  axi_stream_rsp_t      tx_rsp_i,
  output logic                 busy_o,
`ifdef AXI_STREAM_PKT_GEN_STATS_EN
  output logic [31:0]          pkt_cnt_o,
  output logic [31:0]          beat_cnt_o,
`endif
  output logic                 pkt_done_o
);

  localparam int unsigned NB = DataWidth / 8;
  localparam logic [LenWidth-1:0] NbLen = LenWidth'(NB);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic                  load_cmd, load_next, done_d;
  logic                  valid_q, last_q, done_q;
  logic [LenWidth-1:0]   rem_q, rem_nx;
  logic [7:0]            base_q, base_nx;
  logic [DataWidth-1:0]  data_q;
  logic [NB-1:0]         keep_q;
  logic [IdWidth-1:0]    id_q;
  logic [DestWidth-1:0]  dest_q;
  logic [UserWidth-1:0]  user_q;

  // rem is the byte count from the start of the beat being built to the end of the packet
  function automatic logic [DataWidth-1:0] beat_data(input logic [7:0] base,
                                                     input logic [LenWidth-1:0] rem);
    logic [DataWidth-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (rem > LenWidth'(i)) d[8*i +: 8] = base + 8'(i);
    end
    return d;
  endfunction

  function automatic logic [NB-1:0] beat_keep(input logic [LenWidth-1:0] rem);
    logic [NB-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (rem > LenWidth'(i)) k[i] = 1'b1;
    end
    return k;
  endfunction

  assign rem_nx  = rem_q - NbLen;
  assign base_nx = base_q + 8'(NB);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_cmd  = 1'b0;
    load_next = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i != '0) begin
            state_d  = SEND;
            load_cmd = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (tx_rsp_i.tready) begin
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register stage: every tx_req_o field comes straight from a flop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else begin
      valid_q <= (state_d == SEND);
      done_q  <= done_d;
      if (load_cmd) begin
        rem_q  <= cmd_len_i;
        base_q <= cmd_seed_i;
        data_q <= beat_data(cmd_seed_i, cmd_len_i);
        keep_q <= beat_keep(cmd_len_i);
        last_q <= (cmd_len_i <= NbLen);
        id_q   <= cmd_id_i;
        dest_q <= cmd_dest_i;
        user_q <= cmd_user_i;
      end else if (load_next) begin
        rem_q  <= rem_nx;
        base_q <= base_nx;
        data_q <= beat_data(base_nx, rem_nx);
        keep_q <= beat_keep(rem_nx);
        last_q <= (rem_nx <= NbLen);
      end
    end
  end

  always_comb begin
    tx_req_o        = '0;
    tx_req_o.tvalid = valid_q;
    tx_req_o.t.data = data_q;
    tx_req_o.t.strb = keep_q;
    tx_req_o.t.keep = keep_q;
    tx_req_o.t.last = last_q;
    tx_req_o.t.id   = id_q;
    tx_req_o.t.dest = dest_q;
    tx_req_o.t.user = user_q;
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == SEND);
  assign pkt_done_o  = done_q;

`ifdef AXI_STREAM_PKT_GEN_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_o  <= '0;
      beat_cnt_o <= '0;
    end else begin
      if (done_q && (pkt_cnt_o != 32'hFFFF_FFFF)) pkt_cnt_o <= pkt_cnt_o + 32'd1;
      if (valid_q && tx_rsp_i.tready && (beat_cnt_o != 32'hFFFF_FFFF))
        beat_cnt_o <= beat_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_pkt_gen.sv
// Directed scoreboard bench for axi_stream_pkt_gen at DataWidth=32.
module tb_axi_stream_pkt_gen;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } tb_axis_t;
  typedef struct packed {
    logic     tvalid;
    tb_axis_t t;
  } tb_req_t;
  typedef struct packed {
    logic tready;
  } tb_rsp_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_len;
  logic [3:0]  cmd_id, cmd_dest;
  logic [0:0]  cmd_user;
  logic [7:0]  cmd_seed;
  tb_req_t     tx_req;
  tb_rsp_t     tx_rsp;
  logic        busy, pkt_done;
`ifdef AXI_STREAM_PKT_GEN_STATS_EN
  logic [31:0] pkt_cnt, beat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;
  int hs_cnt = 0, hs_cyc = 0, hs_prev_cyc = 0, last_hs_cyc = 0;

  always #5 clk = ~clk;

  axi_stream_pkt_gen #(
    .DataWidth(32), .IdWidth(4), .DestWidth(4), .UserWidth(1), .LenWidth(16),
    .axi_stream_req_t(tb_req_t), .axi_stream_rsp_t(tb_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_len_i(cmd_len), .cmd_id_i(cmd_id), .cmd_dest_i(cmd_dest),
    .cmd_user_i(cmd_user), .cmd_seed_i(cmd_seed),
    .tx_req_o(tx_req), .tx_rsp_i(tx_rsp), .busy_o(busy),
`ifdef AXI_STREAM_PKT_GEN_STATS_EN
    .pkt_cnt_o(pkt_cnt), .beat_cnt_o(beat_cnt),
`endif
    .pkt_done_o(pkt_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-wise reference: byte k = seed+k in lane k%4 of beat k/4
  task automatic push_pkt(input int len, input logic [7:0] seed, input logic [3:0] id,
                          input logic [3:0] dest, input logic [0:0] user);
    int nbeats;
    exp_t e;
    nbeats = (len + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      e = '0;
      for (int lane = 0; lane < 4; lane++) begin
        if (b*4 + lane < len) begin
          e.data[lane*8 +: 8] = seed + 8'(b*4 + lane);
          e.keep[lane] = 1'b1;
        end
      end
      e.last = (b == nbeats - 1);
      e.id = id; e.dest = dest; e.user = user;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (pkt_done) begin done_cnt++; done_cyc = cyc; end
      if (tx_req.tvalid) begin
        chk("busy_in_send", 64'(busy), 64'(1));
        chk("cmd_ready_in_send", 64'(cmd_ready), 64'(0));
      end
      if (tx_req.tvalid && tx_rsp.tready) begin
        hs_cnt++;
        hs_prev_cyc = hs_cyc;
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(tx_req.tvalid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(tx_req.t.data), 64'(e.data));
          chk("tkeep", 64'(tx_req.t.keep), 64'(e.keep));
          chk("tstrb", 64'(tx_req.t.strb), 64'(e.keep));
          chk("tlast", 64'(tx_req.t.last), 64'(e.last));
          chk("tid_tdest_tuser", 64'({tx_req.t.id, tx_req.t.dest, tx_req.t.user}),
              64'({e.id, e.dest, e.user}));
          if (e.last) last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after acceptance
  task automatic send_cmd(input int len, input logic [7:0] seed, input logic [3:0] id,
                          input logic [3:0] dest, input logic [0:0] user);
    int n;
    cmd_valid = 1'b1; cmd_len = 16'(len); cmd_seed = seed;
    cmd_id = id; cmd_dest = dest; cmd_user = user;
    if (len != 0) push_pkt(len, seed, id, dest, user);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin n++; @(negedge clk); end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_pkt(input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (exp_q.size() != 0 && n < 200);
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
    step();
    chk({tag, "_done_pulse"}, 64'(pkt_done), 64'(1));
    chk({tag, "_done_after_last"}, 64'(done_cyc - last_hs_cyc), 64'(1));
    chk({tag, "_tvalid_dropped"}, 64'(tx_req.tvalid), 64'(0));
    chk({tag, "_cmd_ready_idle"}, 64'(cmd_ready), 64'(1));
    step();
    chk({tag, "_done_single"}, 64'(pkt_done), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tb_axis_t snap;
    int d0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_id = '0; cmd_dest = '0;
    cmd_user = '0; cmd_seed = '0; tx_rsp.tready = 1'b0;
    repeat (3) @(posedge clk);
    step();
    chk("rst_tvalid", 64'(tx_req.tvalid), 64'(0));
    chk("rst_t", 64'(tx_req.t), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(pkt_done), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // zero-length command
    tx_rsp.tready = 1'b1;
    send_cmd(0, 8'h55, 4'h1, 4'h2, 1'b0);
    step();
    chk("zlen_done", 64'(pkt_done), 64'(1));
    chk("zlen_no_tvalid", 64'(tx_req.tvalid), 64'(0));
    chk("zlen_busy", 64'(busy), 64'(0));
    step();
    chk("zlen_done_single", 64'(pkt_done), 64'(0));
    chk("zlen_no_beat", 64'(hs_cnt), 64'(0));
`ifdef AXI_STREAM_PKT_GEN_STATS_EN
    chk("zlen_pkt_cnt", 64'(pkt_cnt), 64'(1));
    chk("zlen_beat_cnt", 64'(beat_cnt), 64'(0));
`endif
    @(posedge clk); #1;

    // len=10 seed=0x10, three beats
    send_cmd(10, 8'h10, 4'h3, 4'h5, 1'b1);
    finish_pkt("len10");

    // len=8 seed=0xFE, byte wrap
    send_cmd(8, 8'hFE, 4'h7, 4'h9, 1'b0);
    finish_pkt("len8_wrap");

    // len=5 with a 3-cycle stall on beat 2
    tx_rsp.tready = 1'b0;
    send_cmd(5, 8'h40, 4'hA, 4'hB, 1'b1);
    tx_rsp.tready = 1'b1;
    @(posedge clk); #1;
    tx_rsp.tready = 1'b0;
    snap = tx_req.t;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_t_stable", 64'(tx_req.t), 64'(snap));
      chk("stall_tvalid", 64'(tx_req.tvalid), 64'(1));
    end
    @(posedge clk); #1;
    tx_rsp.tready = 1'b1;
    finish_pkt("len5_stall");

    // two queued commands back to back
    d0 = done_cnt;
    send_cmd(4, 8'h01, 4'h2, 4'h3, 1'b0);
    send_cmd(4, 8'h80, 4'h4, 4'h6, 1'b1);
    finish_pkt("b2b");
    chk("b2b_one_bubble", 64'(hs_cyc - hs_prev_cyc), 64'(2));
    chk("b2b_done_count", 64'(done_cnt - d0), 64'(2));

    // reset asserted during beat 2 of len=12
    send_cmd(12, 8'h20, 4'h5, 4'h5, 1'b0);
    n = hs_cnt;
    step();
    chk("rst_mid_beat1", 64'(hs_cnt - n), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(tx_req.tvalid), 64'(0));
    chk("rst_mid_tlast", 64'(tx_req.t.last), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_mid_quiet", 64'(tx_req.tvalid), 64'(0));
    @(posedge clk); #1;
    send_cmd(4, 8'h33, 4'h6, 4'h1, 1'b1);
    finish_pkt("post_rst");
`ifdef AXI_STREAM_PKT_GEN_STATS_EN
    chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'(1));
    chk("post_rst_beat_cnt", 64'(beat_cnt), 64'(1));
`endif

    chk("total_done_pulses", 64'(done_cnt), 64'(7));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_pkt_gen.md
Name: axi_stream_pkt_gen

Overview:
- Command-driven AXI4-Stream transmitter that acts as a traffic source.
- Each accepted command yields one packet: a byte-incrementing payload with tkeep/tstrb and tlast generated per beat.
- Sits at the head of a stream path, e.g. feeding axi_stream_multicut chains, DMA test paths or loopback benches.
- Output uses the codebase req/rsp struct convention.

Parameters:
- DataWidth, 64, tdata width in bits; multiple of 8; NB = DataWidth/8 bytes per beat.
- IdWidth, 4, tid width.
- DestWidth, 4, tdest width.
- UserWidth, 1, tuser width.
- LenWidth, 16, width of the packet byte-length field.
- axi_stream_req_t, logic, request struct with fields tvalid and t.{data,strb,keep,last,id,dest,user}.
- axi_stream_rsp_t, logic, response struct with field tready.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_len_i  in  LenWidth  packet length in bytes
- cmd_id_i  in  IdWidth  tid for all beats of the packet
- cmd_dest_i  in  DestWidth  tdest for all beats
- cmd_user_i  in  UserWidth  tuser for all beats
- cmd_seed_i  in  8  value of payload byte 0
- tx_req_o  out  struct  AXI stream request (transmit port)
- tx_rsp_i  in  struct  AXI stream response
- busy_o  out  1  high while a packet is in flight
- pkt_done_o  out  1  one-cycle pulse when a packet completes

Behaviour:
- FSM states: IDLE, SEND.
- cmd_ready_o = (state==IDLE). A command is accepted on cmd_valid_i && cmd_ready_o; all command fields are registered on acceptance.
- Acceptance with cmd_len_i != 0:
  - Go to SEND.
  - tx_req_o.tvalid rises the next cycle. All outputs are registered; there is no combinational path from cmd_* or tready to tx_req_o.
- Acceptance with cmd_len_i == 0:
  - Stay in IDLE; emit no beat.
  - pkt_done_o pulses the next cycle.
- Payload:
  - Packet byte k = (seed + k) mod 256; byte k sits in lane k mod NB of beat k div NB.
  - Beats = ceil(len/NB); the beat counter is LenWidth bits.
  - Non-last beats: keep = strb = all ones.
  - Last beat: keep = strb = low (len mod NB) lanes, or all ones if the remainder is 0; inactive lanes drive data 0.
  - tlast = 1 on the last beat only. id/dest/user are constant across the packet.
- Handshake:
  - Beat transfers when tvalid && tready.
  - While tvalid is high and tready is low, the whole tx_req_o.t payload is held stable.
  - tvalid never drops without a handshake.
  - On a non-last transfer, the next beat is presented the following cycle (one beat per cycle under continuous tready).
- Last-beat handshake:
  - tvalid drops, FSM returns to IDLE, pkt_done_o pulses in the same cycle tvalid drops.
  - cmd_ready_o is high that cycle, so there is exactly one bubble cycle between back-to-back packets.
- busy_o = (state==SEND).
- Reset (asynchronous, any time, including mid-packet):
  - state=IDLE; tvalid=0; all t fields 0; pkt_done_o=0; busy_o=0.
  - The in-flight packet is abandoned (no tlast).
  - cmd_ready_o=1 from the first cycle after reset deassertion.
- Length wrap: len = 2^LenWidth-1 is legal; no counter overflow.

Optional Feature:
- Macro: AXI_STREAM_PKT_GEN_STATS_EN.
- Defined: adds outputs pkt_cnt_o[31:0] and beat_cnt_o[31:0].
  - pkt_cnt_o increments on each pkt_done_o pulse, including zero-length commands.
  - beat_cnt_o increments on each tx handshake.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
All scenarios use DataWidth=32 (NB=4).
- len=10, seed=0x10, tready=1 -> 3 beats:
  - data 0x13121110, 0x17161514, 0x00001918;
  - keep 0xF, 0xF, 0x3; tlast only on beat 3;
  - pkt_done_o pulses once, the cycle after beat 3.
- len=8, seed=0xFE -> beat data 0x0100FFFE, 0x05040302 (byte wrap); last keep=0xF.
- len=5; tready low for 3 cycles mid-beat 2 -> tx_req_o.t unchanged during the stall; tvalid stays 1; the beat completes when tready rises.
- cmd_valid_i held high with 2 queued commands (len=4, len=4), tready=1:
  - cmd_ready_o is low during SEND;
  - exactly 1 idle cycle between the two tlast-terminated single beats.
- len=0 -> no tvalid; pkt_done_o pulses 1 cycle after acceptance; with the macro defined, pkt_cnt_o=1 and beat_cnt_o=0.
- rst_ni asserted during beat 2 of len=12 -> tvalid=0 immediately; after release, a new len=4 command produces a single beat with tlast=1 and keep=0xF.
